// File: rtl/mem_stage_if.sv
// ---------------------------------------------------------------------------
// mem_stage_if -- data-RAM request/response bus used by the MEM stage.
//
//   ram_en          request valid; held high until ram_ack is seen
//   ram_write_en    byte-lane write strobes (all zero for a load)
//   ram_addr        word-aligned byte address
//   ram_write_data  store data, replicated across the lanes
//   ram_ack         RAM has completed the request this cycle
//   ram_read_data   load data, valid in the ram_ack cycle
//
// master: the pipeline (mem_stage).  slave: the data RAM.
// ---------------------------------------------------------------------------
interface mem_stage_if;
  logic        ram_en;
  logic [3:0]  ram_write_en;
  logic [31:0] ram_addr;
  logic [31:0] ram_write_data;
  logic        ram_ack;
  logic [31:0] ram_read_data;

  modport master (
    output ram_en, ram_write_en, ram_addr, ram_write_data,
    input  ram_ack, ram_read_data
  );

  modport slave (
    input  ram_en, ram_write_en, ram_addr, ram_write_data,
    output ram_ack, ram_read_data
  );
endinterface

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage -- memory-access stage of a 5-stage MIPS-style pipeline.
//
// Issues at most one data-RAM request per instruction, stalls the front of
// the pipeline while a request is outstanding, and formats load data
// (lane extraction plus zero/sign extension) for write-back.
//
// Ports
//   clk, rst                 clock; synchronous active-high reset
//   flush                    discard the current instruction
//   stall_current_stage      controller is holding this stage
//   mem_*_in                 load/store control, size, store data
//   result_in                ALU result / effective address
//   reg_write_*_in           GPR write-back control
//   current_pc_addr_in       PC of the instruction
//   ram                      data-RAM bus (mem_stage_if.master)
//   result_out, reg_write_*_out, current_pc_addr_out   to MEM/WB
//   stall_request            ask the controller to freeze IF..MEM
//   address_error_out, bad_vaddr_out   misalignment report
//
// Build option: define MEM_ADDR_CHECK_EN to flag misaligned half/word
// accesses and suppress their RAM request and write-back. Without it,
// misaligned accesses proceed with truncated byte enables.
// ---------------------------------------------------------------------------
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        stall_current_stage,
  input  logic        mem_read_flag_in,
  input  logic        mem_write_flag_in,
  input  logic        mem_sign_ext_flag_in,
  input  logic [3:0]  mem_sel_in,
  input  logic [31:0] mem_write_data_in,
  input  logic [31:0] result_in,
  input  logic        reg_write_en_in,
  input  logic [4:0]  reg_write_addr_in,
  input  logic [31:0] current_pc_addr_in,
  mem_stage_if.master ram,
  output logic [31:0] result_out,
  output logic        reg_write_en_out,
  output logic [4:0]  reg_write_addr_out,
  output logic [31:0] current_pc_addr_out,
  output logic        stall_request,
  output logic        address_error_out,
  output logic [31:0] bad_vaddr_out
);

  // IDLE : no request outstanding (same-cycle acks complete here)
  // WAIT : request issued, waiting for ram_ack, pipeline frozen
  // DONE : data captured, instruction still held; do not re-issue
  // DRAIN: instruction flushed, finishing the orphaned request
  typedef enum logic [1:0] {IDLE, WAIT, DONE, DRAIN} state_t;

  state_t      state;
  logic [31:0] data_buf;
  logic [1:0]  offset;
  logic        addr_err;
  logic        access;
  logic [31:0] load_src;
  logic [31:0] lane;
  logic [31:0] load_data;
  logic [31:0] store_data;
  logic        ram_en_c;
  logic        stall_c;

  assign offset = result_in[1:0];

`ifdef MEM_ADDR_CHECK_EN
  always_comb begin
    addr_err = 1'b0;
    if (!rst && (mem_read_flag_in || mem_write_flag_in)) begin
      if (mem_sel_in == 4'b0011)      addr_err = offset[0];
      else if (mem_sel_in == 4'b1111) addr_err = (offset != 2'b00);
    end
  end
  assign bad_vaddr_out = addr_err ? result_in : 32'h0;
`else
  assign addr_err      = 1'b0;
  assign bad_vaddr_out = 32'h0;
`endif

  assign address_error_out = addr_err;
  assign access = (mem_read_flag_in | mem_write_flag_in) & ~flush & ~addr_err;

  // Store data is replicated so every enabled lane carries the right bytes.
  always_comb begin
    // NOTE: every always_comb output gets a default first so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    store_data = mem_write_data_in;
    case (mem_sel_in)
      4'b0001: store_data = {4{mem_write_data_in[7:0]}};
      4'b0011: store_data = {2{mem_write_data_in[15:0]}};
      default: ;
    endcase
  end

  // Load data comes straight off the bus except in DONE, where the bus has
  // moved on and the captured copy must be used.
  assign load_src = (state == DONE) ? data_buf : ram.ram_read_data;
  assign lane     = load_src >> {offset, 3'b000};

  always_comb begin
    load_data = lane;
    case (mem_sel_in)
      4'b0001: load_data = mem_sign_ext_flag_in ? {{24{lane[7]}}, lane[7:0]}
                                                : {24'h0, lane[7:0]};
      4'b0011: load_data = mem_sign_ext_flag_in ? {{16{lane[15]}}, lane[15:0]}
                                                : {16'h0, lane[15:0]};
      default: ;
    endcase
  end

  // Request and stall are combinational so a same-cycle ack costs no bubble.
  always_comb begin
    ram_en_c = 1'b0;
    stall_c  = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          ram_en_c = access;
          stall_c  = access & ~ram.ram_ack;
        end
        WAIT: begin
          ram_en_c = 1'b1;
          stall_c  = ~flush;
        end
        DRAIN:   ram_en_c = 1'b1;   // a request is never abandoned
        default: ;                  // DONE: nothing issued while held
      endcase
    end
  end

  assign ram.ram_en         = ram_en_c;
  assign ram.ram_addr       = {result_in[31:2], 2'b00};
  // Shift in 4-bit context: lanes past byte 3 are dropped.
  assign ram.ram_write_en   = (ram_en_c && mem_write_flag_in) ? (mem_sel_in << offset) : 4'b0000;
  assign ram.ram_write_data = store_data;
  assign stall_request      = stall_c;

  assign result_out          = mem_read_flag_in ? load_data : result_in;
  assign reg_write_en_out    = reg_write_en_in & ~flush & ~addr_err & ~rst;
  assign reg_write_addr_out  = reg_write_addr_in;
  assign current_pc_addr_out = current_pc_addr_in;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (rst) begin
      // NOTE: data_buf is a single register, not a memory array, so it is
      // cheap to clear and gives a defined load value after reset.
      state    <= IDLE;
      data_buf <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (access) begin
            if (ram.ram_ack) begin
              data_buf <= ram.ram_read_data;
              if (stall_current_stage) state <= DONE;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (flush) begin
            state <= ram.ram_ack ? IDLE : DRAIN;
          end else if (ram.ram_ack) begin
            data_buf <= ram.ram_read_data;
            state    <= DONE;
          end
        end
        DONE:  if (flush || !stall_current_stage) state <= IDLE;
        DRAIN: if (ram.ram_ack) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
